// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared widths, entry/response types and helpers for the data SRAM responder
package data_sram_responder_pkg;

  localparam int DSRAM_DATA_WD  = 32;
  localparam int DSRAM_ADDR_WD  = 32;
  localparam int DSRAM_STRB_WD  = 4;
  localparam int DSRAM_TIMER_WD = 3;

  // Response-queue entry: {wr, rdata_cap, timer}.
  localparam int DSRAM_ENTRY_WD = 1 + DSRAM_DATA_WD + DSRAM_TIMER_WD;

  // Request bus: req, wr, wstrb, addr, wdata. Response bus: data_ok, rdata.
  localparam int DSRAM_REQ_WD = 1 + 1 + DSRAM_STRB_WD + DSRAM_ADDR_WD + DSRAM_DATA_WD;
  localparam int DSRAM_RSP_WD = 1 + DSRAM_DATA_WD;

  typedef struct packed {
    logic                      wr;
    logic [DSRAM_DATA_WD-1:0]  rdata_cap;
    logic [DSRAM_TIMER_WD-1:0] timer;
  } dsram_entry_t;

  typedef struct packed {
    logic                     data_ok;
    logic [DSRAM_DATA_WD-1:0] rdata;
  } dsram_rsp_t;

  // Store responses and not-yet-ready heads always present zero data.
  function automatic logic [DSRAM_DATA_WD-1:0] dsram_load_data(input dsram_entry_t e,
                                                               input logic ready);
    return (ready && !e.wr) ? e.rdata_cap : '0;
  endfunction

endpackage

// File: rtl/data_sram_responder_fifo.sv
// rtl/data_sram_responder_fifo.sv - in-order response queue with per-entry latency aging
module dsram_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     push_wr_i,
  input  logic [DSRAM_DATA_WD-1:0] push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output dsram_entry_t             head_entry_o,
  output logic                     head_ready_o
);

  localparam int PTR_WD = $clog2(FIFO_DEPTH);
  localparam int CNT_WD = PTR_WD + 1;
  localparam logic [DSRAM_TIMER_WD-1:0] LAT = DSRAM_TIMER_WD'(LATENCY);

  dsram_entry_t      entries_q [FIFO_DEPTH];
  dsram_entry_t      entries_d [FIFO_DEPTH];
  logic [PTR_WD-1:0] wptr_q, wptr_d;
  logic [PTR_WD-1:0] rptr_q, rptr_d;
  logic [CNT_WD-1:0] count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o       = (count_q == CNT_WD'(FIFO_DEPTH));
  assign head_entry_o = entries_q[rptr_q];
  assign head_ready_o = (count_q != '0) && (entries_q[rptr_q].timer == LAT);

  // A full queue never takes a push, even when the head pops in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & head_ready_o;

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entries_q[i].timer < LAT) begin
        entries_d[i].timer = entries_q[i].timer + DSRAM_TIMER_WD'(1);
      end
    end
    if (push_ok) begin
      entries_d[wptr_q] = '{wr: push_wr_i, rdata_cap: push_data_i, timer: DSRAM_TIMER_WD'(1)};
    end
    wptr_d  = push_ok ? wptr_q + PTR_WD'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PTR_WD'(1) : rptr_q;
    count_d = count_q + CNT_WD'(push_ok) - CNT_WD'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - sram-like data RAM slave with fixed-latency in-order responses
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     wr,
  input  logic [DSRAM_STRB_WD-1:0] wstrb,
  input  logic [DSRAM_ADDR_WD-1:0] addr,
  input  logic [DSRAM_DATA_WD-1:0] wdata,
  output logic                     addr_ok,
  output logic                     data_ok,
  output logic [DSRAM_DATA_WD-1:0] rdata,
  input  logic                     rsp_ready
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DSRAM_DATA_WD-1:0] mem_q [WORDS];
  logic [DEPTH_LOG2-1:0]    word_idx;
  logic                     unused_addr_bits;
  logic                     fifo_full;
  logic                     accept;
  logic                     pop;
  logic                     head_ready;
  dsram_entry_t             head_entry;
  logic [DSRAM_DATA_WD-1:0] load_word;
  dsram_rsp_t               rsp;

  // Byte offset and bits above the RAM size are dropped, so the RAM aliases.
  assign word_idx         = addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{addr[1:0], addr[DSRAM_ADDR_WD-1:DEPTH_LOG2+2]};

  assign accept    = req & ~fifo_full & ~reset;
  assign load_word = wr ? '0 : mem_q[word_idx];

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < DSRAM_STRB_WD; b++) begin
        if (wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  dsram_resp_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LATENCY    (LATENCY)
  ) u_resp_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (accept),
    .push_wr_i    (wr),
    .push_data_i  (load_word),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .head_entry_o (head_entry),
    .head_ready_o (head_ready)
  );

  assign pop = head_ready & rsp_ready;

  assign rsp.data_ok = head_ready;
  assign rsp.rdata   = dsram_load_data(head_entry, head_ready);

  assign addr_ok = ~fifo_full;
  assign data_ok = rsp.data_ok;
  assign rdata   = rsp.rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - self-checking bench for data_sram_responder
module tb_data_sram_responder;

  localparam int L0 = 1;
  localparam int FD = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, wr, rsp_ready;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req3, wr3, rsp_ready3;
  logic [3:0]  wstrb3;
  logic [31:0] addr3, wdata3;
  logic        addr_ok3, data_ok3;
  logic [31:0] rdata3;

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(L0), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .rsp_ready(rsp_ready)
  );

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(3), .FIFO_DEPTH(FD)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .wr(wr3), .wstrb(wstrb3), .addr(addr3),
    .wdata(wdata3), .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3),
    .rsp_ready(rsp_ready3)
  );

  // Reference model: outstanding responses with their age in edges since acceptance.
  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          age;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mm [1024];

  int          n_assert = 0;
  int          n_fail   = 0;
  string       phase    = "init";

  logic        obs_aok, obs_dok, obs3_dok;
  logic [31:0] obs_rdata, obs3_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req = r; wr = w; addr = a; wdata = d; wstrb = s;
  endtask

  // One clock cycle: compare outputs against the model mid-cycle, then advance the model.
  task automatic step();
    logic        e_aok, e_dok;
    logic [31:0] e_rd;
    bit          acc, pop;
    int          w;
    @(negedge clk);
    obs_aok = addr_ok; obs_dok = data_ok; obs_rdata = rdata;
    obs3_dok = data_ok3; obs3_rdata = rdata3;
    e_aok = (mq.size() < FD);
    e_dok = (mq.size() > 0) && (mq[0].age >= L0);
    e_rd  = (e_dok && !mq[0].wr) ? mq[0].data : 32'h0;
    check("addr_ok", 32'(addr_ok), 32'(e_aok));
    check("data_ok", 32'(data_ok), 32'(e_dok));
    check("rdata", rdata, e_rd);
    acc = req && e_aok;
    pop = e_dok && rsp_ready;
    w   = int'((addr >> 2) & 32'h3ff);
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age = mq[i].age + 1;
      if (acc) begin
        if (wr) begin
          for (int b = 0; b < 4; b++) if (wstrb[b]) mm[w][8*b +: 8] = wdata[8*b +: 8];
          mq.push_back('{1'b1, 32'h0, 1});
        end else begin
          mq.push_back('{1'b0, mm[w], 1});
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] v3 [3];
    logic [31:0] t3_first;
    logic [31:0] a;
    logic        aok_h [5];
    logic        dok_h [5];
    int          n;

    reset = 1'b1; rsp_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    req3 = 0; wr3 = 0; wstrb3 = 0; addr3 = 0; wdata3 = 0; rsp_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    phase = "reset";
    step();
    check("reset_addr_ok", 32'(obs_aok), 32'd1);
    check("reset_data_ok", 32'(obs_dok), 32'd0);
    check("reset_rdata", obs_rdata, 32'h0);

    phase = "init";
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 32'(4 * i), $urandom, 4'hF);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();

    phase = "t1";
    drive(1, 1, 32'h10, 32'hDEADBEEF, 4'hF); step();
    drive(1, 0, 32'h10, 32'h0, 4'h0);        step();
    check("store_rsp_ok", 32'(obs_dok), 32'd1);
    check("store_rsp_rdata", obs_rdata, 32'h0);
    drive(0, 0, 0, 0, 0); step();
    check("load_rsp_ok", 32'(obs_dok), 32'd1);
    check("load_rsp_rdata", obs_rdata, 32'hDEADBEEF);

    phase = "t2";
    drive(1, 1, 32'h20, 32'h11223344, 4'hF); step();
    drive(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101); step();
    drive(1, 0, 32'h20, 32'h0, 4'h0); step();
    drive(0, 0, 0, 0, 0); step();
    check("byte_merge", obs_rdata, 32'h11BB33DD);

    phase = "t3";
    t3_first = mm[0];
    rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 32'(4 * i) | 32'h0000_3000, 32'h0, 4'h0);
      step();
      if (obs_aok) n++;
    end
    check("accepts_when_stalled", 32'(n), 32'd4);
    check("held_data_ok", 32'(obs_dok), 32'd1);
    check("held_rdata", obs_rdata, t3_first);
    drive(0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      step();
      aok_h[p] = obs_aok;
      dok_h[p] = obs_dok;
    end
    check("full_first_pop_addr_ok", 32'(aok_h[0]), 32'd0);
    check("after_pop_addr_ok", 32'(aok_h[1]), 32'd1);
    check("drain_data_ok_pattern",
          {28'h0, dok_h[0], dok_h[1], dok_h[2], dok_h[3]}, 32'hF);
    check("drain_done", 32'(dok_h[4]), 32'd0);

    phase = "t4";
    for (int i = 0; i < 3; i++) begin
      v3[i] = $urandom;
      req3 = 1; wr3 = 1; addr3 = 32'(4 * i); wdata3 = v3[i]; wstrb3 = 4'hF;
      step();
    end
    req3 = 0; wr3 = 0; wstrb3 = 0;
    repeat (6) step();
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        req3 = 1; wr3 = 0; addr3 = 32'(4 * c);
      end else begin
        req3 = 0;
      end
      step();
      check("lat3_data_ok", 32'(obs3_dok), (c >= 3 && c <= 5) ? 32'd1 : 32'd0);
      check("lat3_rdata", obs3_rdata, (c >= 3 && c <= 5) ? v3[c-3] : 32'h0);
    end

    phase = "t5";
    drive(1, 1, 32'h30, 32'h5A5A1234, 4'hF); step();
    rsp_ready = 1'b0;
    drive(1, 0, 32'h4, 0, 0); step();
    drive(1, 0, 32'h8, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    reset = 1'b1; step();
    reset = 1'b0; step();
    check("post_reset_data_ok", 32'(obs_dok), 32'd0);
    check("post_reset_addr_ok", 32'(obs_aok), 32'd1);
    rsp_ready = 1'b1;
    n = 0;
    repeat (3) begin
      step();
      if (obs_dok) n++;
    end
    check("no_stale_rsp", 32'(n), 32'd0);
    drive(1, 0, 32'h30, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("store_survives_reset", obs_rdata, 32'h5A5A1234);

    phase = "t6";
    drive(1, 1, 32'h0, 32'hCAFEF00D, 4'hF); step();
    drive(1, 0, 32'h1003, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("alias_rdata", obs_rdata, 32'hCAFEF00D);

    phase = "rand";
    repeat (400) begin
      a = $urandom;
      a[11:6] = 6'h0;
      drive(logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 1)), a,
            $urandom, 4'($urandom));
      rsp_ready = logic'($urandom_range(0, 99) < 70);
      step();
    end
    drive(0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    repeat (8) step();
    check("final_drained", 32'(obs_dok), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
